// File: rtl/fib_job_scheduler_if.sv
// Client and generator channels of fib_job_scheduler.
// master = environment (requesters + generator), slave = the scheduler itself.
interface fib_job_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_max;
  logic [N_REQ-1:0]       grant;
  logic                   busy;
  logic                   term_valid;
  logic [WIDTH-1:0]       term_data;
  logic                   job_done;
  logic                   job_err;
  logic                   gen_rst;
  logic                   gen_enable;
  logic [WIDTH-1:0]       gen_max_value;
  logic [WIDTH-1:0]       gen_fib_out;
  logic                   gen_done;

  modport master (
    output req, req_max, gen_fib_out, gen_done,
    input  grant, busy, term_valid, term_data, job_done, job_err,
           gen_rst, gen_enable, gen_max_value
  );

  modport slave (
    input  req, req_max, gen_fib_out, gen_done,
    output grant, busy, term_valid, term_data, job_done, job_err,
           gen_rst, gen_enable, gen_max_value
  );
endinterface

// File: rtl/fib_job_scheduler.sv
// Round-robin scheduler sharing one Fibonacci generator among N_REQ requesters.
// Optional RUN-cycle watchdog enabled by defining FIB_SCHED_TIMEOUT_EN.
module fib_job_scheduler #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input logic                clk,
  input logic                rst,
  fib_job_scheduler_if.slave bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    CLR   = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic [IDX_W-1:0] rr_r, rr_s, owner_r, owner_s, winner_s, idx_s;
  logic             winner_found_s;
  logic [N_REQ-1:0] grant_r, grant_s;
  logic [WIDTH-1:0] max_r, max_s, term_data_r, term_data_s;
  logic             job_err_r, job_err_s;
  logic             busy_r, term_valid_r, job_done_r, gen_rst_r, gen_enable_r;
  logic             timeout_s;

`ifdef FIB_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] run_cnt_r;

  // Count RUN cycles; zero outside RUN so the first RUN cycle sees 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == RUN) begin
      run_cnt_r <= run_cnt_r + CNT_W'(1);
    end else begin
      run_cnt_r <= {CNT_W{1'b0}};
    end
  end

  assign timeout_s = (run_cnt_r == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // Round-robin search: walk offsets high to low so the nearest set bit wins.
  always_comb begin
    winner_s       = rr_r;
    winner_found_s = 1'b0;
    idx_s          = rr_r;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx_s = IDX_W'((int'(rr_r) + i) % N_REQ);
      if (bus.req[idx_s]) begin
        winner_s       = idx_s;
        winner_found_s = 1'b1;
      end else begin
        winner_found_s = winner_found_s;
      end
    end
  end

  // Next-state and next-value logic for the job sequence.
  always_comb begin
    state_s     = state_r;
    grant_s     = grant_r;
    max_s       = max_r;
    owner_s     = owner_r;
    rr_s        = rr_r;
    job_err_s   = job_err_r;
    term_data_s = term_data_r;
    case (state_r)
      IDLE: begin
        if (|bus.req) begin
          state_s = ARB;
        end else begin
          state_s = IDLE;
        end
      end
      ARB: begin
        if (winner_found_s) begin
          state_s = CLR;
          owner_s = winner_s;
          grant_s = N_REQ'(1) << winner_s;
          max_s   = bus.req_max[winner_s*WIDTH +: WIDTH];
        end else begin
          state_s = IDLE;
        end
      end
      CLR: begin
        state_s = RUN;
      end
      RUN: begin
        term_data_s = bus.gen_fib_out;
        // Completion has priority over withdrawal and timeout.
        if (bus.gen_done) begin
          state_s   = DRAIN;
          job_err_s = 1'b0;
        end else if (!bus.req[owner_r] || timeout_s) begin
          state_s   = DRAIN;
          job_err_s = 1'b1;
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        state_s = IDLE;
        grant_s = {N_REQ{1'b0}};
        if (owner_r == IDX_W'(N_REQ - 1)) begin
          rr_s = {IDX_W{1'b0}};
        end else begin
          rr_s = owner_r + IDX_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        grant_s = {N_REQ{1'b0}};
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered outputs, derived from the upcoming state so they align with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_r      <= {N_REQ{1'b0}};
      max_r        <= {WIDTH{1'b0}};
      owner_r      <= {IDX_W{1'b0}};
      rr_r         <= {IDX_W{1'b0}};
      job_err_r    <= 1'b0;
      term_data_r  <= {WIDTH{1'b0}};
      busy_r       <= 1'b0;
      term_valid_r <= 1'b0;
      job_done_r   <= 1'b0;
      gen_rst_r    <= 1'b1;
      gen_enable_r <= 1'b0;
    end else begin
      grant_r      <= grant_s;
      max_r        <= max_s;
      owner_r      <= owner_s;
      rr_r         <= rr_s;
      job_err_r    <= job_err_s;
      term_data_r  <= term_data_s;
      busy_r       <= (state_s != IDLE);
      term_valid_r <= (state_r == RUN) && (state_s == RUN);
      job_done_r   <= (state_s == DRAIN);
      gen_rst_r    <= (state_s == IDLE) || (state_s == ARB) || (state_s == CLR);
      gen_enable_r <= (state_s == RUN);
    end
  end

  assign bus.grant         = grant_r;
  assign bus.busy          = busy_r;
  assign bus.term_valid    = term_valid_r;
  assign bus.term_data     = term_data_r;
  assign bus.job_done      = job_done_r;
  assign bus.job_err       = job_err_r;
  assign bus.gen_rst       = gen_rst_r;
  assign bus.gen_enable    = gen_enable_r;
  assign bus.gen_max_value = max_r;
endmodule
